// File: rtl/hex_loader_pkg.sv
// Shared types and constants for the UART Intel-HEX loader.
// Contents: FSM state enum, record-type codes, error codes, field widths,
// and a helper that keeps the first error code once err is set.
package hex_loader_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 9;   // LL (max 255) + 4 header bytes + CC

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FIELD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [BYTE_W-1:0] REC_DATA      = 8'h00;
    localparam logic [BYTE_W-1:0] REC_EOF       = 8'h01;
    localparam logic [BYTE_W-1:0] REC_EXT_LIN   = 8'h04;
    localparam logic [BYTE_W-1:0] REC_START_LIN = 8'h05;

    localparam logic [BYTE_W-1:0] ASCII_COLON = 8'h3A;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_HEX  = 3'd1;
    localparam logic [2:0] ERR_CSUM = 3'd2;
    localparam logic [2:0] ERR_TYPE = 3'd3;
    localparam logic [2:0] ERR_LEN  = 3'd4;

    // Error code latch: only the first error is reported.
    function automatic logic [2:0] first_code(input logic       err,
                                              input logic [2:0] cur,
                                              input logic [2:0] code);
        return err ? cur : code;
    endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// ASCII hex digit to nibble decoder (combinational).
// Ports: ascii  - input byte
//        nibble - decoded value 0..15 (0 when invalid)
//        valid  - high for 0-9, A-F, a-f
module hex_nibble_decode (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = 4'h0;
        valid  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = 4'(ascii - 8'h30);
            valid  = 1'b1;
        end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
            nibble = 4'(ascii - 8'h37);
            valid  = 1'b1;
        end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
            nibble = 4'(ascii - 8'h57);
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Intel-HEX boot loader: parses ASCII records from an RX FIFO, writes
// type-00 data bytes to memory, tracks the extended linear base (04) and
// start address (05), and releases the CPU after a clean EOF (01).
// Ports: clk_i/rst_i (sync active-high reset), rx_valid_i/rx_data_i/rx_ready_o
//        FIFO pop interface, mem_req_o/mem_addr_o/mem_wdata_o/mem_wstrb_o/
//        mem_ack_i byte-lane write port, cpu_hold_o, entry_pc_o, done_o,
//        err_o, err_code_o status.
module uart_hex_loader
    import hex_loader_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8010_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    output logic              rx_ready_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic              mem_ack_i,
    output logic              cpu_hold_o,
    output logic [ADDR_W-1:0] entry_pc_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        err_code_o
);

    state_t state, state_d;

    logic [BYTE_W-1:0] rec_len, rec_len_d;
    logic [15:0]       rec_addr, rec_addr_d;
    logic [BYTE_W-1:0] rec_type, rec_type_d;
    logic [BYTE_W-1:0] csum, csum_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [3:0]        hi_nib, hi_nib_d;
    logic              phase, phase_d;
    logic [DATA_W-1:0] acc, acc_d;
    logic [15:0]       base_hi16, base_hi16_d;

    logic              rx_ready_d, mem_req_d, cpu_hold_d, done_d, err_d;
    logic [ADDR_W-1:0] mem_addr_d, entry_pc_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_d;
    logic [2:0]        err_code_d;

    logic              pop;
    logic [3:0]        nib;
    logic              nib_ok;
    logic [BYTE_W-1:0] byte_val;
    logic [BYTE_W-1:0] sum_new;
    logic              in_start;
    logic [BYTE_W-1:0] ctx_csum;
    logic [CNT_W-1:0]  ctx_cnt;
    logic              ctx_phase;
    logic [ADDR_W-1:0] wr_addr;

    hex_nibble_decode u_dec (
        .ascii  (rx_data_i),
        .nibble (nib),
        .valid  (nib_ok)
    );

    assign pop      = rx_valid_i & rx_ready_o;
    assign byte_val = {hi_nib, nib};

    // START clears the record context in the same cycle it may consume the
    // first LL digit, so field handling sees a zeroed context there.
    assign in_start  = (state == ST_START);
    assign ctx_csum  = in_start ? '0 : csum;
    assign ctx_cnt   = in_start ? '0 : cnt;
    assign ctx_phase = in_start ? 1'b0 : phase;
    assign sum_new   = ctx_csum + byte_val;
    assign wr_addr   = {base_hi16, rec_addr} + ADDR_W'(ctx_cnt - CNT_W'(4));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        rec_len_d   = rec_len;
        rec_addr_d  = rec_addr;
        rec_type_d  = rec_type;
        csum_d      = csum;
        cnt_d       = cnt;
        hi_nib_d    = hi_nib;
        phase_d     = phase;
        acc_d       = acc;
        base_hi16_d = base_hi16;
        mem_req_d   = mem_req_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        mem_wstrb_d = mem_wstrb_o;
        entry_pc_d  = entry_pc_o;
        done_d      = done_o;
        err_d       = err_o;
        err_code_d  = err_code_o;

        case (state)
            ST_IDLE: begin
                if (pop && rx_data_i == ASCII_COLON) state_d = ST_START;
            end
            ST_START, ST_FIELD: begin
                state_d = ST_FIELD;
                csum_d  = ctx_csum;
                cnt_d   = ctx_cnt;
                phase_d = ctx_phase;
                if (pop) begin
                    if (rx_data_i == ASCII_COLON) begin
                        err_d      = 1'b1;
                        err_code_d = first_code(err_o, err_code_o, ERR_LEN);
                        state_d    = ST_START;
                    end else if (!nib_ok) begin
                        err_d      = 1'b1;
                        err_code_d = first_code(err_o, err_code_o, ERR_HEX);
                        state_d    = ST_IDLE;
                    end else if (!ctx_phase) begin
                        hi_nib_d = nib;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        csum_d  = sum_new;
                        cnt_d   = ctx_cnt + CNT_W'(1);
                        if (ctx_cnt == CNT_W'(0)) begin
                            rec_len_d = byte_val;
                        end else if (ctx_cnt == CNT_W'(1)) begin
                            rec_addr_d[15:8] = byte_val;
                        end else if (ctx_cnt == CNT_W'(2)) begin
                            rec_addr_d[7:0] = byte_val;
                        end else if (ctx_cnt == CNT_W'(3)) begin
                            rec_type_d = byte_val;
                            // Reject unsupported types and bad lengths before any data.
                            case (byte_val)
                                REC_DATA: state_d = ST_FIELD;
                                REC_EOF: begin
                                    if (rec_len != 8'd0) begin
                                        err_d      = 1'b1;
                                        err_code_d = first_code(err_o, err_code_o, ERR_LEN);
                                        state_d    = ST_IDLE;
                                    end
                                end
                                REC_EXT_LIN: begin
                                    if (rec_len != 8'd2) begin
                                        err_d      = 1'b1;
                                        err_code_d = first_code(err_o, err_code_o, ERR_LEN);
                                        state_d    = ST_IDLE;
                                    end
                                end
                                REC_START_LIN: begin
                                    if (rec_len != 8'd4) begin
                                        err_d      = 1'b1;
                                        err_code_d = first_code(err_o, err_code_o, ERR_LEN);
                                        state_d    = ST_IDLE;
                                    end
                                end
                                default: begin
                                    err_d      = 1'b1;
                                    err_code_d = first_code(err_o, err_code_o, ERR_TYPE);
                                    state_d    = ST_IDLE;
                                end
                            endcase
                        end else if (ctx_cnt == CNT_W'(rec_len) + CNT_W'(4)) begin
                            state_d = ST_CHECK;
                        end else begin
                            acc_d = {acc[23:0], byte_val};
                            if (rec_type == REC_DATA) begin
                                state_d     = ST_WRITE;
                                mem_req_d   = 1'b1;
                                mem_addr_d  = {wr_addr[ADDR_W-1:2], 2'b00};
                                mem_wdata_d = {4{byte_val}};
                                mem_wstrb_d = 4'b0001 << wr_addr[1:0];
                            end
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack_i) begin
                    mem_req_d   = 1'b0;
                    mem_wstrb_d = '0;
                    state_d     = ST_FIELD;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (csum != 8'h00) begin
                    err_d      = 1'b1;
                    err_code_d = first_code(err_o, err_code_o, ERR_CSUM);
                end else begin
                    case (rec_type)
                        REC_EXT_LIN:   base_hi16_d = acc[15:0];
                        REC_START_LIN: entry_pc_d  = acc;
                        REC_EOF: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_START) || (state_d == ST_FIELD);
        cpu_hold_d = !(done_o && !err_o);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rec_len     <= '0;
            rec_addr    <= '0;
            rec_type    <= '0;
            csum        <= '0;
            cnt         <= '0;
            hi_nib      <= '0;
            phase       <= 1'b0;
            acc         <= '0;
            base_hi16   <= '0;
            rx_ready_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            cpu_hold_o  <= 1'b1;
            entry_pc_o  <= RESET_PC;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
        end else begin
            state       <= state_d;
            rec_len     <= rec_len_d;
            rec_addr    <= rec_addr_d;
            rec_type    <= rec_type_d;
            csum        <= csum_d;
            cnt         <= cnt_d;
            hi_nib      <= hi_nib_d;
            phase       <= phase_d;
            acc         <= acc_d;
            base_hi16   <= base_hi16_d;
            rx_ready_o  <= rx_ready_d;
            mem_req_o   <= mem_req_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            mem_wstrb_o <= mem_wstrb_d;
            cpu_hold_o  <= cpu_hold_d;
            entry_pc_o  <= entry_pc_d;
            done_o      <= done_d;
            err_o       <= err_d;
            err_code_o  <= err_code_d;
        end
    end

endmodule

// File: doc/uart_hex_loader.md
UART_HEX_LOADER -- requirements
Module: uart_hex_loader

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8010_0000, meaning the entry_pc_o value when no type-05 record has been seen.
REQ-002 SHALL have port clk_i, input, 1, the single clock domain.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port rx_valid_i, input, 1, high when an RX FIFO byte is available.
REQ-005 SHALL have port rx_data_i, input, 8, the ASCII byte from the RX FIFO.
REQ-006 SHALL have port rx_ready_o, output, 1, the pop strobe; a byte is consumed when rx_valid_i & rx_ready_o.
REQ-007 SHALL have port mem_req_o, output, 1, the memory write request.
REQ-008 SHALL have ports mem_addr_o (output, 32, word-aligned byte address), mem_wdata_o (output, 32, data with the byte replicated on all lanes) and mem_wstrb_o (output, 4, one-hot lane = address[1:0]).
REQ-009 SHALL have port mem_ack_i, input, 1, write accepted.
REQ-010 SHALL have port cpu_hold_o, output, 1, holding the CPU core in reset while high.
REQ-011 SHALL have ports entry_pc_o (output, 32, boot address), done_o (output, 1, EOF accepted) and err_o (output, 1, sticky error).
REQ-012 SHALL have port err_code_o, output, 3: 1 = bad hex char, 2 = checksum, 3 = unsupported type, 4 = length mismatch.

Function
REQ-013 SHALL implement FSM states IDLE, START, FIELD, WRITE, CHECK, DONE.
REQ-014 In IDLE, SHALL consume and discard every byte except ':', which moves the FSM to START.
REQ-015 START SHALL clear the running checksum and byte counter, then move to FIELD.
REQ-016 FIELD SHALL collect hex-digit pairs as LL, AAAA, TT, LL data bytes, then CC.
REQ-017 Hex digits 0-9, A-F and a-f SHALL be accepted; any other byte inside a record SHALL go to IDLE with error code 1.
REQ-018 Each assembled byte SHALL be added mod 256 to the checksum.
REQ-019 For type 00, each data byte SHALL enter WRITE with address = {base_hi16, AAAA} + index.
REQ-020 In WRITE, mem_req_o SHALL stay high with stable addr/data/strb until mem_ack_i, and rx_ready_o SHALL be low.
REQ-021 After mem_ack_i, the FSM SHALL return to FIELD on the following cycle.
REQ-022 An ack in the same cycle as the request SHALL make WRITE last exactly one cycle.
REQ-023 The address add SHALL be 32-bit and wrap modulo 2^32 without error.
REQ-024 After CC, CHECK SHALL require checksum == 8'h00, else error code 2.
REQ-025 Type 04 SHALL require LL = 2 (else code 4) and load base_hi16 on a good checksum.
REQ-026 Type 05 SHALL require LL = 4 and load entry_pc_o on a good checksum.
REQ-027 Type 01 SHALL require LL = 0 and go to DONE on a good checksum.
REQ-028 Types 02, 03 and >05 SHALL be code 3, detected at TT before any data.
REQ-029 Type 00 data SHALL be written as it streams; a bad checksum flags an error but does not undo writes.
REQ-030 err_o SHALL be sticky once set, err_code_o SHALL keep the first error, and parsing SHALL resume at the next ':'.
REQ-031 A ':' received mid-record SHALL restart the record (go to START) and raise code 4.
REQ-032 DONE SHALL set done_o and keep rx_ready_o low; done_o and DONE are left only by reset.
REQ-033 cpu_hold_o SHALL be 0 only when done_o & !err_o, and SHALL drop the cycle after DONE is entered.
REQ-034 rx_ready_o SHALL be high in IDLE, START and FIELD, and low otherwise.

Reset
REQ-035 On rst_i, state SHALL be IDLE and rx_ready_o = 0 for the reset cycle.
REQ-036 On rst_i, mem_req_o = 0, mem_wstrb_o = 0, cpu_hold_o = 1, done_o = 0, err_o = 0 and err_code_o = 0.
REQ-037 On rst_i, base_hi16 = 0 and entry_pc_o = RESET_PC.
REQ-038 Reset during WRITE SHALL drop mem_req_o immediately; the pending write is abandoned.

Structure
REQ-039 Package hex_loader_pkg SHALL hold the state enum, record-type constants 00/01/04/05 and error-code constants.
REQ-040 Sub-module hex_nibble_decode SHALL be used: 8-bit ASCII in, 4-bit nibble plus valid out, combinational.
REQ-041 All other logic SHALL be in a single clocked process plus next-state logic.

Verification
REQ-042 Stream ":0200000480106A\r\n" -> base_hi16 = 8010; no write, no error.
REQ-043 Then stream ":1000000037C50100130525F51300000067800000C7\r\n" -> 16 writes starting at address 8010_0000 strb 0001 data 37373737, ending at 8010_000C strb 1000 byte 00.
REQ-044 Then stream ":040000058010000067\r\n:00000001FF\r\n" -> entry_pc_o = 8010_0000, done_o = 1, cpu_hold_o falls.
REQ-045 Hold mem_ack_i low for 5 cycles during a write -> mem_req_o and the address stay stable and no RX byte is consumed.
REQ-046 Send ":00000001FE" -> err_o = 1, code 2, done_o = 0, cpu_hold_o = 1; a following valid EOF gives done_o = 1 with cpu_hold_o still 1.
REQ-047 Send ":02G0..." -> code 1; send type 02 -> code 3; assert reset mid-WRITE -> all outputs return to their reset values.
